// File: rtl/dual_port_ram_arbiter.sv
// Two-client write and two-client read arbiter in front of a simple dual-port RAM.
// Round-robin per port, no back-to-back grants, read withheld on a same-address write collision.
module dual_port_ram_arbiter #(
    parameter int unsigned DATA_WIDTH    = 16,
    parameter int unsigned ADDRESS_SIZE  = 3,
    parameter int unsigned ADDRESS_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w0_req,
    input  logic                    w1_req,
    input  logic [ADDRESS_SIZE-1:0] w0_addr,
    input  logic [ADDRESS_SIZE-1:0] w1_addr,
    input  logic [DATA_WIDTH-1:0]   w0_data,
    input  logic [DATA_WIDTH-1:0]   w1_data,
    output logic                    w0_gnt,
    output logic                    w1_gnt,
    input  logic                    r0_req,
    input  logic                    r1_req,
    input  logic [ADDRESS_SIZE-1:0] r0_addr,
    input  logic [ADDRESS_SIZE-1:0] r1_addr,
    output logic                    r0_gnt,
    output logic                    r1_gnt,
    output logic                    r0_valid,
    output logic                    r1_valid,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic                    we,
    output logic [ADDRESS_SIZE-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    re,
    output logic [ADDRESS_SIZE-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]   rd_data
);

    if (ADDRESS_DEPTH != (32'd1 << ADDRESS_SIZE)) begin : g_depth_check
        $error("ADDRESS_DEPTH must equal 2**ADDRESS_SIZE");
    end

    // last-granted client per port: 1 means client 1, so client 0 wins the first conflict
    logic w_last;
    logic r_last;

    logic                    w_elig0, w_elig1, w_sel0, w_sel1, w_any;
    logic                    r_elig0, r_elig1, r_pick0, r_pick1, r_pick_any;
    logic                    hazard, r_sel0, r_sel1, r_any;
    logic [ADDRESS_SIZE-1:0] w_addr_win, r_addr_win;
    logic [DATA_WIDTH-1:0]   w_data_win;

    // arbitration for the next edge
    always_comb begin
        w_elig0    = 1'b0;
        w_elig1    = 1'b0;
        w_sel0     = 1'b0;
        w_sel1     = 1'b0;
        w_any      = 1'b0;
        w_addr_win = w0_addr;
        w_data_win = w0_data;
        r_elig0    = 1'b0;
        r_elig1    = 1'b0;
        r_pick0    = 1'b0;
        r_pick1    = 1'b0;
        r_pick_any = 1'b0;
        r_addr_win = r0_addr;
        hazard     = 1'b0;
        r_sel0     = 1'b0;
        r_sel1     = 1'b0;
        r_any      = 1'b0;

        w_elig0 = w0_req & ~w0_gnt;
        w_elig1 = w1_req & ~w1_gnt;
        w_sel1  = w_elig1 & (~w_elig0 | ~w_last);
        w_sel0  = w_elig0 & ~w_sel1;
        w_any   = w_sel0 | w_sel1;
        if (w_sel1) begin
            w_addr_win = w1_addr;
            w_data_win = w1_data;
        end

        r_elig0    = r0_req & ~r0_gnt;
        r_elig1    = r1_req & ~r1_gnt;
        r_pick1    = r_elig1 & (~r_elig0 | ~r_last);
        r_pick0    = r_elig0 & ~r_pick1;
        r_pick_any = r_pick0 | r_pick1;
        if (r_pick1) begin
            r_addr_win = r1_addr;
        end

        // a read colliding with this edge's write waits one edge so it sees the new data
        hazard = r_pick_any & w_any & (r_addr_win == w_addr_win);
        r_sel0 = r_pick0 & ~hazard;
        r_sel1 = r_pick1 & ~hazard;
        r_any  = r_sel0 | r_sel1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w0_gnt   <= 1'b0;
            w1_gnt   <= 1'b0;
            r0_gnt   <= 1'b0;
            r1_gnt   <= 1'b0;
            we       <= 1'b0;
            re       <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            rd_addr  <= '0;
            r0_valid <= 1'b0;
            r1_valid <= 1'b0;
            w_last   <= 1'b1;
            r_last   <= 1'b1;
        end else begin
            w0_gnt   <= w_sel0;
            w1_gnt   <= w_sel1;
            we       <= w_any;
            r0_gnt   <= r_sel0;
            r1_gnt   <= r_sel1;
            re       <= r_any;
            r0_valid <= r0_gnt;
            r1_valid <= r1_gnt;
            if (w_any) begin
                wr_addr <= w_addr_win;
                wr_data <= w_data_win;
                w_last  <= w_sel1;
            end
            if (r_any) begin
                rd_addr <= r_addr_win;
                r_last  <= r_sel1;
            end
        end
    end

    // shared return bus: RAM data only while a valid is up
    always_comb begin
        r_data = '0;
        if (r0_valid | r1_valid) begin
            r_data = rd_data;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Directed table-driven bench for dual_port_ram_arbiter with a one-cycle-latency RAM model.
module tb_dual_port_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        w0_req, w1_req, r0_req, r1_req;
    logic [2:0]  w0_addr, w1_addr, r0_addr, r1_addr;
    logic [15:0] w0_data, w1_data;
    logic        w0_gnt, w1_gnt, r0_gnt, r1_gnt, r0_valid, r1_valid;
    logic [15:0] r_data;
    logic        we, re;
    logic [2:0]  wr_addr, rd_addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic [15:0] mem [8];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        rst;
        logic        w0r;
        logic [2:0]  w0a;
        logic [15:0] w0d;
        logic        w1r;
        logic [2:0]  w1a;
        logic [15:0] w1d;
        logic        r0r;
        logic [2:0]  r0a;
        logic        r1r;
        logic [2:0]  r1a;
    } in_t;

    typedef struct packed {
        logic        w0g;
        logic        w1g;
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic        r0g;
        logic        r1g;
        logic        re;
        logic [2:0]  ra;
        logic        v0;
        logic        v1;
        logic [15:0] rd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    vec_t tbl[$];

    dual_port_ram_arbiter #(
        .DATA_WIDTH   (16),
        .ADDRESS_SIZE (3),
        .ADDRESS_DEPTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .w0_req  (w0_req),
        .w1_req  (w1_req),
        .w0_addr (w0_addr),
        .w1_addr (w1_addr),
        .w0_data (w0_data),
        .w1_data (w1_data),
        .w0_gnt  (w0_gnt),
        .w1_gnt  (w1_gnt),
        .r0_req  (r0_req),
        .r1_req  (r1_req),
        .r0_addr (r0_addr),
        .r1_addr (r1_addr),
        .r0_gnt  (r0_gnt),
        .r1_gnt  (r1_gnt),
        .r0_valid(r0_valid),
        .r1_valid(r1_valid),
        .r_data  (r_data),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .re      (re),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    // RAM: write on we, read data available the cycle after re
    always @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end

    function automatic in_t mi(input int r, input int w0r, input int w0a, input int w0d,
                               input int w1r, input int w1a, input int w1d,
                               input int r0r, input int r0a, input int r1r, input int r1a);
        in_t v;
        v.rst = 1'(r);
        v.w0r = 1'(w0r);
        v.w0a = 3'(w0a);
        v.w0d = 16'(w0d);
        v.w1r = 1'(w1r);
        v.w1a = 3'(w1a);
        v.w1d = 16'(w1d);
        v.r0r = 1'(r0r);
        v.r0a = 3'(r0a);
        v.r1r = 1'(r1r);
        v.r1a = 3'(r1a);
        return v;
    endfunction

    function automatic out_t mo(input int w0g, input int w1g, input int wen, input int wa, input int wd,
                                input int r0g, input int r1g, input int ren, input int ra,
                                input int v0, input int v1, input int rd);
        out_t v;
        v.w0g = 1'(w0g);
        v.w1g = 1'(w1g);
        v.we  = 1'(wen);
        v.wa  = 3'(wa);
        v.wd  = 16'(wd);
        v.r0g = 1'(r0g);
        v.r1g = 1'(r1g);
        v.re  = 1'(ren);
        v.ra  = 3'(ra);
        v.v0  = 1'(v0);
        v.v1  = 1'(v1);
        v.rd  = 16'(rd);
        return v;
    endfunction

    task automatic drive(input in_t v);
        rst     = v.rst;
        w0_req  = v.w0r;
        w0_addr = v.w0a;
        w0_data = v.w0d;
        w1_req  = v.w1r;
        w1_addr = v.w1a;
        w1_data = v.w1d;
        r0_req  = v.r0r;
        r0_addr = v.r0a;
        r1_req  = v.r1r;
        r1_addr = v.r1a;
    endtask

    task automatic check(input out_t exp, input string name);
        out_t act;
        act = out_t'{w0_gnt, w1_gnt, we, wr_addr, wr_data, r0_gnt, r1_gnt, re, rd_addr,
                     r0_valid, r1_valid, r_data};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got gnt_w=%b%b we=%b wa=%0d wd=%h gnt_r=%b%b re=%b ra=%0d v=%b%b rd=%h | want gnt_w=%b%b we=%b wa=%0d wd=%h gnt_r=%b%b re=%b ra=%0d v=%b%b rd=%h",
                     name, act.w0g, act.w1g, act.we, act.wa, act.wd, act.r0g, act.r1g, act.re,
                     act.ra, act.v0, act.v1, act.rd, exp.w0g, exp.w1g, exp.we, exp.wa, exp.wd,
                     exp.r0g, exp.r1g, exp.re, exp.ra, exp.v0, exp.v1, exp.rd);
        end
    endtask

    task automatic step(input in_t i, input out_t o, input string name);
        drive(i);
        @(posedge clk);
        #1;
        check(o, name);
    endtask

    initial begin
        rd_data = '0;
        // reset, then single write
        tbl.push_back('{mi(1, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,0,0,          0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 1,2,'hF00F, 0,0,0,      0,0, 0,0), mo(1,0,1,2,'hF00F,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,2,'hF00F,     0,0,0,0, 0,0,0)});
        // write conflict: w0 granted last, so w1 goes first, then alternate
        tbl.push_back('{mi(0, 1,1,'h1111, 1,6,'h6666, 0,0, 0,0), mo(0,1,1,6,'h6666,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 1,1,'h1111, 1,6,'h6667, 0,0, 0,0), mo(1,0,1,1,'h1111,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 1,1,'h1111, 1,6,'h6667, 0,0, 0,0), mo(0,1,1,6,'h6667,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 1,1,'h1111, 1,6,'h6667, 0,0, 0,0), mo(1,0,1,1,'h1111,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,1,'h1111,     0,0,0,0, 0,0,0)});
        // write then read back through client 1
        tbl.push_back('{mi(0, 0,0,0,      1,5,'h0F0F, 0,0, 0,0), mo(0,1,1,5,'h0F0F,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,5,'h0F0F,     0,0,0,0, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 1,5), mo(0,0,0,5,'h0F0F,     0,1,1,5, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,5,'h0F0F,     0,0,0,5, 0,1,'h0F0F)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,5,'h0F0F,     0,0,0,5, 0,0,0)});
        // same-address hazard: read deferred one edge
        tbl.push_back('{mi(0, 1,3,'hAAAA, 0,0,0,      1,3, 0,0), mo(1,0,1,3,'hAAAA,     0,0,0,5, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,3, 0,0), mo(0,0,0,3,'hAAAA,     1,0,1,3, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,3, 1,0,'hAAAA)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,3, 0,0,0)});
        // single reader held high: every other cycle
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,2, 0,0), mo(0,0,0,3,'hAAAA,     1,0,1,2, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,2, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,2, 1,0,'hF00F)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,2, 0,0), mo(0,0,0,3,'hAAAA,     1,0,1,2, 0,0,0)});
        // both readers continuous: alternate
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,1, 1,6), mo(0,0,0,3,'hAAAA,     0,1,1,6, 1,0,'hF00F)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,1, 1,6), mo(0,0,0,3,'hAAAA,     1,0,1,1, 0,1,'h6667)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,1, 1,6), mo(0,0,0,3,'hAAAA,     0,1,1,6, 1,0,'h1111)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,6, 0,1,'h6667)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,6, 0,0,0)});
        // fresh read conflict after r1 last: r0 wins; r1 drops its request
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      1,2, 1,5), mo(0,0,0,3,'hAAAA,     1,0,1,2, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,2, 1,0,'hF00F)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,3,'hAAAA,     0,0,0,2, 0,0,0)});
        // concurrent write and read to different addresses
        tbl.push_back('{mi(0, 0,0,0,      1,4,'hBEEF, 0,0, 1,5), mo(0,1,1,4,'hBEEF,     0,1,1,5, 0,0,0)});
        tbl.push_back('{mi(0, 0,0,0,      0,0,0,      0,0, 0,0), mo(0,0,0,4,'hBEEF,     0,0,0,5, 0,1,'h0F0F)});

        drive(tbl[0].i);
        for (int k = 0; k < tbl.size(); k++) begin
            step(tbl[k].i, tbl[k].o, $sformatf("row%0d", k));
        end

        // read granted, then reset during the grant cycle; pointers must return to client 0
        step(mi(0, 1,0,'h5555, 0,0,0, 1,5, 0,0), mo(1,0,1,0,'h5555, 1,0,1,5, 0,0,0), "pre_reset_grant");
        step(mi(1, 0,0,0,      0,0,0, 0,0, 0,0), mo(0,0,0,0,0,      0,0,0,0, 0,0,0), "reset_clears");
        step(mi(0, 0,0,0,      0,0,0, 0,0, 0,0), mo(0,0,0,0,0,      0,0,0,0, 0,0,0), "no_valid_after_reset");
        step(mi(0, 1,4,'h1234, 1,7,'h7777, 1,1, 1,2), mo(1,0,1,4,'h1234, 1,0,1,1, 0,0,0), "rr_reset_client0");
        step(mi(0, 0,0,0,      1,7,'h7777, 0,0, 1,2), mo(0,1,1,7,'h7777, 0,1,1,2, 1,0,'h1111), "rr_then_client1");
        step(mi(0, 0,0,0,      0,0,0, 0,0, 0,0), mo(0,0,0,7,'h7777, 0,0,0,2, 0,1,'hF00F), "post_reset_read");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
